// File: rtl/dco_generator.sv
// dco_generator
// -------------
// Digitally controlled oscillator for the ADPLL loop. Divides fpga_clk_i
// into the square wave generated_o. Each output level lasts hp cycles.
// hp is NOMINAL_HALF_PERIOD plus a signed tune word, clamped to
// [MIN_HALF_PERIOD, MAX_HALF_PERIOD]. A new tune word only takes effect at a
// rising edge of generated_o, so a period is never cut part way through.
//
// Optional build macro: DCO_FRACTIONAL_EN
//   When defined, tune_i carries 2 fractional bits. The integer part sets hp.
//   The fraction feeds a 2-bit accumulator that stretches a level by one
//   cycle each time the accumulator carries out.
//
// Ports
//   fpga_clk_i     in   sole clock
//   reset_n_i      in   asynchronous active-low reset
//   enable_i       in   run oscillator; low holds generated_o low
//   tune_i         in   signed half-period offset from nominal
//   tune_valid_i   in   tune word offered
//   tune_ready_o   out  block can accept a tune word
//   generated_o    out  generated clock (registered)
//   rising_edge_o  out  one-cycle pulse in the first cycle generated_o is 1
//   half_period_o  out  currently applied half-period
//   clamp_o        out  applied half-period is a clamped value
//
// Tune handshake (valid/ready): a word transfers on a clock edge where
// tune_valid_i and tune_ready_o are both high. tune_ready_o is a registered
// state: it is low while a word is pending. The source must hold tune_i and
// tune_valid_i stable until the transfer. Nothing is dropped or overwritten.
// The pending word is applied at the next rise of generated_o. tune_ready_o
// returns high in the cycle after that rise.

module dco_generator #(
  parameter int WIDTH               = 20,
  parameter int NOMINAL_HALF_PERIOD = 40,
  parameter int MIN_HALF_PERIOD     = 2,
  parameter int MAX_HALF_PERIOD     = 4000
) (
  input  logic             fpga_clk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] tune_i,
  input  logic             tune_valid_i,
  output logic             tune_ready_o,
  output logic             generated_o,
  output logic             rising_edge_o,
  output logic [WIDTH-1:0] half_period_o,
  output logic             clamp_o
);

  localparam logic signed [WIDTH:0] NOM_S = (WIDTH+1)'(NOMINAL_HALF_PERIOD);
  localparam logic signed [WIDTH:0] MIN_S = (WIDTH+1)'(MIN_HALF_PERIOD);
  localparam logic signed [WIDTH:0] MAX_S = (WIDTH+1)'(MAX_HALF_PERIOD);

  logic [WIDTH-1:0] hp;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;
  logic             pending_valid;
  logic             gen_q;
  logic             rise_q;
  logic             clamp_q;

  // Combinational helpers
  logic signed [WIDTH-1:0] offset;
  logic signed [WIDTH:0]   sum;
  logic                    sum_lo;
  logic                    sum_hi;
  logic [WIDTH-1:0]        hp_next;
  logic [WIDTH-1:0]        level_last;
  logic                    level_done;
  logic                    accept;
  logic                    apply;

`ifdef DCO_FRACTIONAL_EN
  logic [1:0] frac;
  logic [1:0] acc;
  logic       extend;
  logic [1:0] frac_next;
  logic [1:0] frac_eff;
  logic [2:0] acc_sum;
`endif

  always_comb begin
`ifdef DCO_FRACTIONAL_EN
    offset = $signed(pending) >>> 2;
`else
    offset = $signed(pending);
`endif
    // One extra bit of headroom: NOMINAL plus any WIDTH-bit offset cannot wrap.
    sum     = NOM_S + $signed({offset[WIDTH-1], offset});
    sum_lo  = (sum < MIN_S);
    sum_hi  = (sum > MAX_S);
    hp_next = sum[WIDTH-1:0];
    if (sum_lo) begin
      hp_next = MIN_S[WIDTH-1:0];
    end else if (sum_hi) begin
      hp_next = MAX_S[WIDTH-1:0];
    end

`ifdef DCO_FRACTIONAL_EN
    // A carried-out accumulator stretches the current level by one cycle.
    level_last = extend ? hp : (hp - WIDTH'(1));
`else
    level_last = hp - WIDTH'(1);
`endif
    level_done = (cnt == level_last);
    accept     = tune_valid_i && !pending_valid;
    // Only the low-to-high toggle may load a new half-period.
    apply      = enable_i && level_done && !gen_q && pending_valid;

`ifdef DCO_FRACTIONAL_EN
    frac_next = (sum_lo || sum_hi) ? 2'b00 : pending[1:0];
    // The newly applied fraction already counts at the toggle that loads it.
    frac_eff  = apply ? frac_next : frac;
    acc_sum   = {1'b0, acc} + {1'b0, frac_eff};
`endif
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hp            <= WIDTH'(NOMINAL_HALF_PERIOD);
      cnt           <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      gen_q         <= 1'b0;
      rise_q        <= 1'b0;
      clamp_q       <= 1'b0;
`ifdef DCO_FRACTIONAL_EN
      frac          <= 2'b00;
      acc           <= 2'b00;
      extend        <= 1'b0;
`endif
    end else begin
      // Acceptance and application are mutually exclusive: the first needs
      // pending_valid low, the second needs it high.
      if (accept) begin
        pending       <= tune_i;
        pending_valid <= 1'b1;
      end else if (apply) begin
        pending_valid <= 1'b0;
      end

      if (!enable_i) begin
        cnt    <= '0;
        gen_q  <= 1'b0;
        rise_q <= 1'b0;
`ifdef DCO_FRACTIONAL_EN
        extend <= 1'b0;
`endif
      end else if (level_done) begin
        cnt    <= '0;
        gen_q  <= ~gen_q;
        rise_q <= ~gen_q;
        if (apply) begin
          hp      <= hp_next;
          clamp_q <= sum_lo || sum_hi;
`ifdef DCO_FRACTIONAL_EN
          frac    <= frac_next;
`endif
        end
`ifdef DCO_FRACTIONAL_EN
        acc    <= acc_sum[1:0];
        extend <= acc_sum[2];
`endif
      end else begin
        cnt    <= cnt + WIDTH'(1);
        rise_q <= 1'b0;
      end
    end
  end

  assign tune_ready_o  = !pending_valid;
  assign generated_o   = gen_q;
  assign rising_edge_o = rise_q;
  assign half_period_o = hp;
  assign clamp_o       = clamp_q;

endmodule
